fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decode stage: owns the PC, issues word requests to instruction memory, buffers returned words in a small FIFO, and presents {instr, instr_pc} to decode with a valid/ready handshake.
- Handles control-flow redirects from execute (taken branch, JAL, JALR) by flushing buffered and in-flight wrong-path fetches.
- Decode consumes instr[6:0] as the opcode.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word
// requests to instruction memory, buffers responses in a small FIFO and
// hands {instr, instr_pc} to decode. Redirects from execute flush the FIFO
// and squash any in-flight wrong-path response.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched/perf_flushed.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_flushed
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    // Occupancy may momentarily be count + 1 before the pop is subtracted.
    localparam int unsigned OCC_W = PTR_W + 2;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] tag_q;
    logic                  outstanding_q;
    logic                  drop_q;
    logic [CNT_W-1:0]      count_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc_q   [DEPTH];

    logic             resp;
    logic             push;
    logic             pop;
    logic             grant;
    logic [OCC_W-1:0] occupancy;

    // Handshake decode and request generation.
    always_comb begin
        // A response only counts when we are actually waiting for one; a stray
        // rvalid after reset is ignored.
        resp        = imem_rvalid && outstanding_q;
        push        = resp && !drop_q;
        instr_valid = !rst && (count_q != '0);
        pop         = instr_valid && instr_ready;
        occupancy   = OCC_W'(count_q) + OCC_W'(push) - OCC_W'(pop);
        imem_req    = !rst && !redirect_en && (!outstanding_q || imem_rvalid) &&
                      (occupancy < OCC_W'(DEPTH));
        grant       = imem_req && imem_gnt;
        imem_addr   = pc_q;
        instr       = fifo_data_q[rd_ptr_q];
        instr_pc    = fifo_pc_q[rd_ptr_q];
    end

    // PC, outstanding/drop tracking and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            tag_q         <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else if (redirect_en) begin
            pc_q     <= redirect_pc & ~ADDR_WIDTH'(3);
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            if (outstanding_q && !imem_rvalid) begin
                // Wrong-path response still to come: swallow it when it lands.
                drop_q <= 1'b1;
            end else begin
                // Either nothing in flight or it lands now and is discarded.
                outstanding_q <= 1'b0;
                drop_q        <= 1'b0;
            end
        end else begin
            if (grant) begin
                pc_q  <= pc_q + ADDR_WIDTH'(4);
                tag_q <= pc_q;
            end
            if (grant) begin
                outstanding_q <= 1'b1;
            end else if (resp) begin
                outstanding_q <= 1'b0;
            end
            if (resp) begin
                drop_q <= 1'b0;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (!rst && !redirect_en && push) begin
            fifo_data_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= tag_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [32:0] flushed_sum;

    // Entries discarded by a redirect, widened to detect saturation.
    always_comb begin
        flushed_sum = {1'b0, perf_flushed} + 33'(count_q) + 33'(outstanding_q);
    end

    // Performance counters; a pop in a redirect cycle is wrong-path.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop && !redirect_en) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect_en) begin
                perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural instruction memory with
// random grant/latency, directed scenarios, and a random run checked against
// an architectural model of the expected instruction stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int checks = 0;
    int errors = 0;

    // Memory model knobs.
    int unsigned gnt_pct   = 100;
    int unsigned delay_min = 1;
    int unsigned delay_max = 1;

    // Memory model state.
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int unsigned pend_cnt = 0;
    int          overlap_cnt = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0013_0093;
    endfunction

    // Memory drives its outputs for the coming edge.
    always @(negedge clk) begin
        if (pend && pend_cnt <= 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(pend_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt = ($urandom_range(99) < gnt_pct);
    end

    // Memory tracks accepted requests; it does not see the fetch reset.
    always @(posedge clk) begin
        if (imem_req && imem_gnt) begin
            if (pend && !imem_rvalid) overlap_cnt <= overlap_cnt + 1;
            pend      <= 1'b1;
            pend_addr <= imem_addr;
            pend_cnt  <= $urandom_range(delay_max, delay_min);
        end else if (imem_rvalid) begin
            pend <= 1'b0;
        end else if (pend) begin
            pend_cnt <= pend_cnt - 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Holds reset for 4 edges; returns at the start of the first live cycle.
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        #1;
        rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; instr_ready = rdy; gnt_pct = 100;
        repeat (4) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            redirect_en = $urandom_range(1); redirect_pc = $urandom; instr_ready = $urandom_range(1);
            #1;
            checks++;
            if (imem_req !== 1'b0) begin
                errors++; $display("FAIL reset_req: got %b want 0", imem_req);
            end
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++; $display("FAIL reset_valid: got %b want 0", instr_valid);
            end
            tick();
        end
        redirect_en = 1'b0; instr_ready = 1'b1; rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_pc: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        delay_min = 1; delay_max = 1;
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stream_addr%0d: got req=%b addr=%h want req=1 addr=%h",
                         k, imem_req, imem_addr, 32'(4 * k));
            end
            checks++;
            if (instr_valid !== (k >= 2)) begin
                errors++; $display("FAIL stream_valid%0d: got %b want %b", k, instr_valid, k >= 2);
            end
            if (k >= 2) begin
                checks++;
                if (instr_pc !== 32'(4 * (k - 2)) || instr !== instr_of(32'(4 * (k - 2)))) begin
                    errors++;
                    $display("FAIL stream_head%0d: got pc=%h instr=%h want pc=%h instr=%h", k,
                             instr_pc, instr, 32'(4 * (k - 2)), instr_of(32'(4 * (k - 2))));
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        delay_min = 1; delay_max = 1;
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k >= 3) begin
                checks++;
                if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin
                    errors++;
                    $display("FAIL stall_req%0d: got req=%b addr=%h want req=0 addr=8",
                             k, imem_req, imem_addr);
                end
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL stall_head%0d: got valid=%b pc=%h want valid=1 pc=0",
                             k, instr_valid, instr_pc);
                end
            end
            tick();
        end
        instr_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=8", imem_req, imem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) #1;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stall_drain%0d: got valid=%b pc=%h want valid=1 pc=%h",
                         k, instr_valid, instr_pc, 32'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_gnt_delay();
        delay_min = 1; delay_max = 1;
        do_reset(1'b1);
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k >= 1 && k <= 4) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
                    errors++;
                    $display("FAIL gnt_hold%0d: got req=%b addr=%h want req=1 addr=4",
                             k, imem_req, imem_addr);
                end
            end
            if (k >= 3 && k <= 5) begin
                checks++;
                if (instr_valid !== 1'b0) begin
                    errors++; $display("FAIL gnt_dup%0d: got valid=%b want 0", k, instr_valid);
                end
            end
            if (k == 2 || k == 6 || k == 7) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== (k == 2 ? 32'h0 : 32'(4 * (k - 5)))) begin
                    errors++;
                    $display("FAIL gnt_head%0d: got valid=%b pc=%h want valid=1 pc=%h", k,
                             instr_valid, instr_pc, (k == 2 ? 32'h0 : 32'(4 * (k - 5))));
                end
            end
            if (k == 0) gnt_pct = 0;
            if (k == 3) gnt_pct = 100;
            tick();
        end
    endtask

    task automatic test_redirect_outstanding();
        delay_min = 2; delay_max = 2;
        do_reset(1'b1);
        tick();
        redirect_en = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL redir_noreq: got %b want 0", imem_req);
        end
        tick();
        redirect_en = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL redir_addr: got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) #1;
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++; $display("FAIL redir_drop%0d: got valid=%b pc=%h want valid=0", k, instr_valid, instr_pc);
            end
            tick();
        end
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== instr_of(32'h100)) begin
            errors++;
            $display("FAIL redir_first: got valid=%b pc=%h instr=%h want valid=1 pc=100 instr=%h",
                     instr_valid, instr_pc, instr, instr_of(32'h100));
        end
    endtask

    task automatic test_redirect_full();
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] flushed_before;
`endif
        delay_min = 1; delay_max = 1;
        do_reset(1'b0);
        repeat (5) tick();
        #1;
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++; $display("FAIL full_state: got valid=%b req=%b want valid=1 req=0", instr_valid, imem_req);
        end
        tick();
        redirect_en = 1'b1; redirect_pc = 32'h203;
`ifdef FETCH_PERF_CNT_EN
        flushed_before = perf_flushed;
`endif
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL full_noreq: got %b want 0", imem_req);
        end
        tick();
        redirect_en = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL full_flush: got valid=%b req=%b addr=%h want valid=0 req=1 addr=200",
                     instr_valid, imem_req, imem_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_flushed !== flushed_before + 32'd2) begin
            errors++; $display("FAIL perf_flushed: got %0d want %0d", perf_flushed, flushed_before + 32'd2);
        end
`endif
        instr_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
            errors++; $display("FAIL full_target: got valid=%b pc=%h want valid=1 pc=200", instr_valid, instr_pc);
        end
    endtask

    task automatic test_reset_mid();
        delay_min = 3; delay_max = 3;
        do_reset(1'b1);
        tick();
        rst = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h400; gnt_pct = 0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_inreset: got req=%b valid=%b want 0 0", imem_req, instr_valid);
        end
        tick();
        rst = 1'b0; redirect_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) #1;
            checks++;
            if (instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
                errors++;
                $display("FAIL rmid_late%0d: got valid=%b addr=%h want valid=0 addr=0", k, instr_valid, imem_addr);
            end
            if (k == 2) begin
                gnt_pct = 100; delay_min = 1; delay_max = 1;
            end
            tick();
        end
        tick();
        tick();
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== instr_of(32'h0)) begin
            errors++;
            $display("FAIL rmid_restart: got valid=%b pc=%h instr=%h want valid=1 pc=0 instr=%h",
                     instr_valid, instr_pc, instr, instr_of(32'h0));
        end
    endtask

    // Random run: the model is the architectural stream -- consecutive
    // word PCs from reset, restarting at each aligned redirect target.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic        prev_wait;
        logic [31:0] prev_addr;
        int          pops;
        exp_pc = 32'h0; prev_wait = 1'b0; prev_addr = '0; pops = 0;
        gnt_pct = 60; delay_min = 1; delay_max = 3;
        do_reset(1'b1);
        gnt_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            redirect_en = ($urandom_range(99) < 4);
            redirect_pc = $urandom;
            instr_ready = ($urandom_range(99) < 70);
            #1;
            if (redirect_en) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++; $display("FAIL rnd_redir_req cyc%0d: got %b want 0", i, imem_req);
                end
            end else if (prev_wait) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL rnd_hold cyc%0d: got req=%b addr=%h want req=1 addr=%h",
                             i, imem_req, imem_addr, prev_addr);
                end
            end
            if (instr_valid && instr_ready && !redirect_en) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== instr_of(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_stream cyc%0d: got pc=%h instr=%h want pc=%h instr=%h",
                             i, instr_pc, instr, exp_pc, instr_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (redirect_en) exp_pc = {redirect_pc[31:2], 2'b00};
            prev_wait = imem_req && !imem_gnt;
            prev_addr = imem_addr;
            tick();
        end
        redirect_en = 1'b0;
        checks++;
        if (pops < 200) begin
            errors++; $display("FAIL rnd_progress: got %0d pops want >= 200", pops);
        end
        checks++;
        if (overlap_cnt !== 0) begin
            errors++; $display("FAIL rnd_single_outstanding: got %0d overlaps want 0", overlap_cnt);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetched !== 32'(pops)) begin
            errors++; $display("FAIL perf_fetched: got %0d want %0d", perf_fetched, pops);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_gnt_delay();
        test_redirect_outstanding();
        test_redirect_full();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
